i2c_byte_master: RTL and testbench

- Synthesizable I2C bus initiator that drives the target side the slave BFM responds to.
- Accepts one byte-level command at a time (START, STOP, WRITE, READ_ACK, READ_NACK) over a valid/ready port and generates SCL/SDA timing from a system-clock prescaler.
- Returns the read data and the ACK/NACK status per command.
- Sits between the DUT-side command logic and the open-drain bus wires; slave-side clock stretching and multi-master arbitration are out of scope.

---
 rtl/i2c_byte_master.sv | 222 ++++++++++++++++++++++
 tb/tb_i2c_byte_master.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_byte_master.sv
// Byte-level I2C bus initiator. Executes one START/STOP/WRITE/READ command at
// a time and builds each SCL/SDA quarter from a system-clock prescaler.
// Every output is a register, and the line levels for a quarter are loaded
// on the clock edge that begins that quarter.
module i2c_byte_master #(
  parameter int CLK_DIV        = 250,
  parameter int I2C_DATA_WIDTH = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [2:0]                cmd_i,
  input  logic [I2C_DATA_WIDTH-1:0] wdata_i,
  output logic                      rsp_valid_o,
  output logic [I2C_DATA_WIDTH-1:0] rdata_o,
  output logic                      nack_o,
  output logic                      err_o,
  output logic                      bus_held_o,
  output logic                      scl_o,
  output logic                      sda_o,
  input  logic                      sda_i
);

  localparam int DW = I2C_DATA_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_START, S_STOP, S_XFER, S_RESP} state_t;
  typedef enum logic [2:0] {OP_START, OP_STOP, OP_WRITE, OP_READ, OP_NOP, OP_ERR} op_t;

  state_t        r_state, w_state_n, w_dec_state;
  op_t           r_op, w_dec_op;
  logic [15:0]   r_cnt, w_cnt_n;
  logic [1:0]    r_q, w_q_n;
  logic [3:0]    r_bit, w_bit_n;
  logic          w_tick, w_accept, w_enter;

  logic [DW-1:0] r_wbyte, r_shift, r_rdata;
  logic          r_ack, r_nack_s, r_nack, r_held;
  logic          r_ready, r_rsp_valid, r_err;
  logic          r_scl, r_sda, w_scl_n, w_sda_n;

  logic [DW-1:0] w_wbyte;
  logic          w_is_read, w_ack, w_bit_sda;
  logic [2:0]    w_idx;

  assign w_accept = cmd_valid_i & r_ready;
  assign w_tick   = (r_cnt == 16'(CLK_DIV - 1));

  // Command decode: illegal or no-op commands go straight to the response state.
  always_comb begin
    w_dec_state = S_RESP;
    w_dec_op    = OP_ERR;
    case (cmd_i)
      3'b000: begin w_dec_state = S_START; w_dec_op = OP_START; end
      3'b001: begin
        if (r_held) begin w_dec_state = S_STOP; w_dec_op = OP_STOP; end
        else        begin w_dec_state = S_RESP; w_dec_op = OP_NOP;  end
      end
      3'b010: if (r_held) begin w_dec_state = S_XFER; w_dec_op = OP_WRITE; end
      3'b011,
      3'b100: if (r_held) begin w_dec_state = S_XFER; w_dec_op = OP_READ; end
      default: ;
    endcase
  end

  // Next state, prescaler, quarter and bit counters; w_enter marks a new quarter.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_q_n     = r_q;
    w_bit_n   = r_bit;
    w_enter   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_cnt_n   = '0;
          w_q_n     = '0;
          w_bit_n   = '0;
          w_state_n = w_dec_state;
          w_enter   = (w_dec_state != S_RESP);
        end
      end
      S_START, S_STOP, S_XFER: begin
        if (w_tick) begin
          w_cnt_n = '0;
          if (r_q == 2'd3) begin
            if (r_state != S_XFER || r_bit == 4'(DW)) begin
              w_state_n = S_RESP;
            end else begin
              w_q_n   = '0;
              w_bit_n = r_bit + 4'd1;
              w_enter = 1'b1;
            end
          end else begin
            w_q_n   = r_q + 2'd1;
            w_enter = 1'b1;
          end
        end else begin
          w_cnt_n = r_cnt + 16'd1;
        end
      end
      S_RESP:  w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  // In the acceptance cycle the operands are not latched yet, so use the inputs.
  assign w_wbyte   = (r_state == S_IDLE) ? wdata_i : r_wbyte;
  assign w_is_read = (r_state == S_IDLE) ? (w_dec_op == OP_READ) : (r_op == OP_READ);
  assign w_ack     = (r_state == S_IDLE) ? (cmd_i == 3'b011) : r_ack;
  assign w_idx     = 3'(4'(DW - 1) - w_bit_n);

  // SDA level for the bit cell being entered; the ninth bit is the ACK slot.
  always_comb begin
    w_bit_sda = 1'b1;
    if (w_bit_n == 4'(DW)) w_bit_sda = w_is_read ? ~w_ack : 1'b1;
    else if (!w_is_read)   w_bit_sda = w_wbyte[w_idx];
  end

  // Line levels for the quarter being entered; otherwise the lines hold.
  always_comb begin
    w_scl_n = r_scl;
    w_sda_n = r_sda;
    if (w_enter) begin
      case (w_state_n)
        S_START: begin
          case (w_q_n)
            2'd0:    begin w_scl_n = ~r_held; w_sda_n = 1'b1; end
            2'd1:    begin w_scl_n = 1'b1;    w_sda_n = 1'b1; end
            2'd2:    begin w_scl_n = 1'b1;    w_sda_n = 1'b0; end
            default: begin w_scl_n = 1'b0;    w_sda_n = 1'b0; end
          endcase
        end
        S_STOP: begin
          case (w_q_n)
            2'd0:    begin w_scl_n = 1'b0; w_sda_n = 1'b0; end
            2'd1:    begin w_scl_n = 1'b1; w_sda_n = 1'b0; end
            default: begin w_scl_n = 1'b1; w_sda_n = 1'b1; end
          endcase
        end
        S_XFER: begin
          w_scl_n = (w_q_n == 2'd1) || (w_q_n == 2'd2);
          w_sda_n = w_bit_sda;
        end
        default: ;
      endcase
    end
  end

  // FSM state and timing counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_q     <= '0;
      r_bit   <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_q     <= w_q_n;
      r_bit   <= w_bit_n;
    end
  end

  // Datapath: operand latch, sampling at the end of q1, result and status update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_op        <= OP_NOP;
      r_wbyte     <= '0;
      r_ack       <= 1'b0;
      r_shift     <= '0;
      r_nack_s    <= 1'b0;
      r_rdata     <= '0;
      r_nack      <= 1'b0;
      r_held      <= 1'b0;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_err       <= 1'b0;
      r_scl       <= 1'b1;
      r_sda       <= 1'b1;
    end else begin
      r_scl       <= w_scl_n;
      r_sda       <= w_sda_n;
      r_ready     <= (w_state_n == S_IDLE);
      r_rsp_valid <= 1'b0;
      r_err       <= 1'b0;
      if (w_accept) begin
        r_op    <= w_dec_op;
        r_wbyte <= wdata_i;
        r_ack   <= (cmd_i == 3'b011);
      end
      if (r_state == S_XFER && w_tick && r_q == 2'd1) begin
        if (r_op == OP_READ) begin
          if (r_bit < 4'(DW)) r_shift <= {r_shift[DW-2:0], sda_i};
        end else if (r_bit == 4'(DW)) begin
          r_nack_s <= sda_i;
        end
      end
      if (r_state == S_RESP) begin
        r_rsp_valid <= 1'b1;
        r_err       <= (r_op == OP_ERR);
        case (r_op)
          OP_START: r_held  <= 1'b1;
          OP_STOP:  r_held  <= 1'b0;
          OP_WRITE: r_nack  <= r_nack_s;
          OP_READ:  r_rdata <= r_shift;
          default:  ;
        endcase
      end
    end
  end

  assign cmd_ready_o = r_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rdata_o     = r_rdata;
  assign nack_o      = r_nack;
  assign err_o       = r_err;
  assign bus_held_o  = r_held;
  assign scl_o       = r_scl;
  assign sda_o       = r_sda;

endmodule

// File: tb/tb_i2c_byte_master.sv
// Bench for i2c_byte_master: a small target model on the wires, a table of
// commands with hand-computed results, then a mid-byte reset sequence.
module tb_i2c_byte_master;

  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd = '0;
  logic [7:0] wdata = '0;
  logic       cmd_ready, rsp_valid, nack, err, held, scl, sda_drv;
  logic [7:0] rdata;
  logic       bfm_sda = 1'b1;
  logic       sda_w, scl_w;

  assign scl_w = scl;
  assign sda_w = sda_drv & bfm_sda;   // open drain with pull-up

  i2c_byte_master #(.CLK_DIV(CLK_DIV), .I2C_DATA_WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_i(cmd), .wdata_i(wdata), .rsp_valid_o(rsp_valid), .rdata_o(rdata),
    .nack_o(nack), .err_o(err), .bus_held_o(held), .scl_o(scl), .sda_o(sda_drv),
    .sda_i(sda_w)
  );

  always #5 clk = ~clk;

  // Target model at address 0x22, transmit data from tx_q.
  int         n_start = 0, n_restart = 0, n_stop = 0;
  logic       active = 1'b0, addressed = 1'b0;
  int         bitn = 0, phase = 0, tx_idx = 0;
  logic [7:0] sh = '0, tx = 8'hFF;
  logic [7:0] tx_q [4] = '{8'hA5, 8'h3C, 8'h5A, 8'hC3};
  logic [7:0] addr_log [$];
  logic       ack_log [$];

  always @(negedge sda_w) if (scl_w && !rst) begin
    if (active) n_restart++; else n_start++;
    active = 1'b1; bitn = 0; phase = 0; addressed = 1'b0; sh = '0;
  end

  always @(posedge sda_w) if (scl_w && !rst) begin
    n_stop++; active = 1'b0;
  end

  always @(posedge scl_w) if (active && !rst) begin
    if (bitn < 8) begin
      if (phase != 2) sh = {sh[6:0], sda_w};
    end else if (phase == 2) begin
      ack_log.push_back(sda_w);
      if (sda_w) addressed = 1'b0;
    end
    bitn++;
    if (bitn == 9) begin
      bitn = 0;
      if (phase == 0) begin
        addr_log.push_back(sh);
        addressed = (sh[7:1] == 7'h22);
        phase = sh[0] ? 2 : 1;
        if (addressed && sh[0]) begin tx = tx_q[tx_idx]; tx_idx++; end
      end else if (phase == 2 && addressed) begin
        tx = tx_q[tx_idx]; tx_idx++;
      end
    end
  end

  always @(negedge scl_w) begin
    bfm_sda = 1'b1;
    if (active && !rst) begin
      if (bitn == 8 && phase == 0 && sh[7:1] == 7'h22)  bfm_sda = 1'b0;
      else if (bitn == 8 && phase == 1 && addressed)     bfm_sda = 1'b0;
      else if (bitn < 8 && phase == 2 && addressed)      bfm_sda = tx[7-bitn];
    end
  end

  always @(posedge rst) begin active = 1'b0; bfm_sda = 1'b1; end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input int idx, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", nm, idx, got, exp);
    end
  endtask

  // Offer a command, wait for acceptance, then count cycles to rsp_valid.
  task automatic run_cmd(input logic [2:0] c, input logic [7:0] d, input int idx,
                         output int lat, output logic to);
    int w;
    to = 1'b0; lat = 0; w = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd = c; wdata = d;
    while (!cmd_ready && w < 1000) begin @(negedge clk); w++; end
    if (w >= 1000) begin to = 1'b1; cmd_valid = 1'b0; return; end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("ready_drop", idx, int'(cmd_ready), 0);
    do begin
      @(posedge clk); lat++;
      @(negedge clk);
    end while (!rsp_valid && lat < 2000);
    if (!rsp_valid) to = 1'b1;
  endtask

  typedef struct {
    logic [2:0] cmd;
    logic [7:0] wd;
    int         lat;
    logic       err, nack;
    logic [7:0] rd;
    logic       held, scl, sda;
  } vec_t;

  function automatic vec_t mk(logic [2:0] c, logic [7:0] d, int l, logic e, logic n,
                              logic [7:0] r, logic h, logic sc, logic sd);
    vec_t v;
    v.cmd = c; v.wd = d; v.lat = l; v.err = e; v.nack = n;
    v.rd = r; v.held = h; v.scl = sc; v.sda = sd;
    return v;
  endfunction

  localparam logic [2:0] C_START = 3'd0, C_STOP = 3'd1, C_WR = 3'd2,
                         C_RDA = 3'd3, C_RDN = 3'd4, C_BAD = 3'd7;
  localparam int L_SS = 1 + 4*CLK_DIV, L_X = 1 + 36*CLK_DIV;

  initial begin
    vec_t vt [20];
    int   lat, pulses;
    logic to;

    vt[0]  = mk(C_START, 8'h00, L_SS, 0, 0, 8'h00, 1, 0, 0);
    vt[1]  = mk(C_WR,    8'h44, L_X,  0, 0, 8'h00, 1, 0, 1);
    vt[2]  = mk(C_STOP,  8'h00, L_SS, 0, 0, 8'h00, 0, 1, 1);
    vt[3]  = mk(C_START, 8'h00, L_SS, 0, 0, 8'h00, 1, 0, 0);
    vt[4]  = mk(C_WR,    8'h45, L_X,  0, 0, 8'h00, 1, 0, 1);
    vt[5]  = mk(C_RDA,   8'h00, L_X,  0, 0, 8'hA5, 1, 0, 0);
    vt[6]  = mk(C_RDN,   8'h00, L_X,  0, 0, 8'h3C, 1, 0, 1);
    vt[7]  = mk(C_STOP,  8'h00, L_SS, 0, 0, 8'h3C, 0, 1, 1);
    vt[8]  = mk(C_START, 8'h00, L_SS, 0, 0, 8'h3C, 1, 0, 0);
    vt[9]  = mk(C_WR,    8'h88, L_X,  0, 1, 8'h3C, 1, 0, 1);
    vt[10] = mk(C_STOP,  8'h00, L_SS, 0, 1, 8'h3C, 0, 1, 1);
    vt[11] = mk(C_RDA,   8'h00, 1,    1, 1, 8'h3C, 0, 1, 1);
    vt[12] = mk(C_BAD,   8'h00, 1,    1, 1, 8'h3C, 0, 1, 1);
    vt[13] = mk(C_STOP,  8'h00, 1,    0, 1, 8'h3C, 0, 1, 1);
    vt[14] = mk(C_START, 8'h00, L_SS, 0, 1, 8'h3C, 1, 0, 0);
    vt[15] = mk(C_WR,    8'h44, L_X,  0, 0, 8'h3C, 1, 0, 1);
    vt[16] = mk(C_START, 8'h00, L_SS, 0, 0, 8'h3C, 1, 0, 0);
    vt[17] = mk(C_WR,    8'h45, L_X,  0, 0, 8'h3C, 1, 0, 1);
    vt[18] = mk(C_RDN,   8'h00, L_X,  0, 0, 8'h5A, 1, 0, 1);
    vt[19] = mk(C_STOP,  8'h00, L_SS, 0, 0, 8'h5A, 0, 1, 1);

    // Reset state and 100 idle cycles.
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    chk("rst_scl", 0, int'(scl), 1);
    chk("rst_sda", 0, int'(sda_drv), 1);
    chk("rst_ready", 0, int'(cmd_ready), 1);
    chk("rst_held", 0, int'(held), 0);
    chk("rst_rdata", 0, int'(rdata), 0);
    chk("rst_nack", 0, int'(nack), 0);
    chk("rst_err", 0, int'(err), 0);
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    chk("idle_rsp", 0, pulses, 0);
    chk("idle_lines", 0, int'({scl, sda_drv, cmd_ready}), 7);

    for (int i = 0; i < 20; i++) begin
      run_cmd(vt[i].cmd, vt[i].wd, i, lat, to);
      chk("timeout", i, int'(to), 0);
      chk("latency", i, lat, vt[i].lat);
      chk("err", i, int'(err), int'(vt[i].err));
      chk("nack", i, int'(nack), int'(vt[i].nack));
      chk("rdata", i, int'(rdata), int'(vt[i].rd));
      chk("held", i, int'(held), int'(vt[i].held));
      chk("scl", i, int'(scl), int'(vt[i].scl));
      chk("sda", i, int'(sda_drv), int'(vt[i].sda));
      chk("ready_rsp", i, int'(cmd_ready), 1);
      @(negedge clk);
      chk("rsp_pulse", i, int'(rsp_valid), 0);
      chk("lines_hold", i, int'({scl, sda_drv}), int'({vt[i].scl, vt[i].sda}));
    end

    // What the target saw on the wires.
    chk("bfm_start", 0, n_start, 4);
    chk("bfm_restart", 0, n_restart, 1);
    chk("bfm_stop", 0, n_stop, 4);
    chk("bfm_naddr", 0, addr_log.size(), 5);
    if (addr_log.size() == 5) begin
      chk("bfm_addr", 0, int'(addr_log[0]), 'h44);
      chk("bfm_addr", 1, int'(addr_log[1]), 'h45);
      chk("bfm_addr", 2, int'(addr_log[2]), 'h88);
      chk("bfm_addr", 3, int'(addr_log[3]), 'h44);
      chk("bfm_addr", 4, int'(addr_log[4]), 'h45);
    end
    chk("bfm_nack", 0, ack_log.size(), 3);
    if (ack_log.size() == 3) begin
      chk("master_ack", 0, int'(ack_log[0]), 0);
      chk("master_ack", 1, int'(ack_log[1]), 1);
      chk("master_ack", 2, int'(ack_log[2]), 1);
    end

    // Reset in the middle of a byte: lines released on the next cycle, no STOP.
    run_cmd(C_START, 8'h00, 100, lat, to);
    chk("mid_start_lat", 100, lat, L_SS);
    @(negedge clk);
    cmd_valid = 1'b1; cmd = C_WR; wdata = 8'h88;
    @(posedge clk);
    @(negedge clk) cmd_valid = 1'b0;
    repeat (60) @(negedge clk);
    chk("mid_busy", 100, int'(cmd_ready), 0);
    chk("mid_scl_low", 100, int'(scl), 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_lines", 100, int'({scl, sda_drv}), 3);
    chk("mid_rst_ready", 100, int'(cmd_ready), 1);
    chk("mid_rst_held", 100, int'(held), 0);
    chk("mid_rst_rsp", 100, int'(rsp_valid), 0);
    chk("mid_rst_nack", 100, int'(nack), 0);
    rst = 1'b0;
    run_cmd(C_START, 8'h00, 101, lat, to);
    chk("post_rst_start", 101, lat, L_SS);
    chk("post_rst_held", 101, int'(held), 1);
    run_cmd(C_STOP, 8'h00, 102, lat, to);
    chk("post_rst_stop", 102, lat, L_SS);
    chk("post_rst_lines", 102, int'({scl, sda_drv, held}), 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
